control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit that sequences the single-bus datapath through fetch, decode and execute for the load/store, ALU, immediate, branch, jump and halt instruction subset. It drives the datapath strobes: register enables, bus source select, ALU select, memory read/write, select-and-encode controls and the CON load. It also waits on a memory-ready handshake with a timeout. It sits beside the datapath in the CPU top level and is the only driver of those controls.

Parameters:
MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready before declaring mem_err (1..255).
ADD_SEL, 6'd3, ALU_Sel code used for address and offset addition.

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous, active-high reset
ir  in  32  IR contents; opcode = ir[31:27]
con_ff  in  1  CON flip-flop output (branch condition)
mem_ready  in  1  memory handshake; completes the current read/write
reg_enable  out  32  datapath load enables: 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 IR, 22 MDR, 23 MAR, 24 Y
bus_sel  out  32  one-hot bus source select: 19 Zlow, 20 PC, 21 MDR, 23 C_sign_extended; GPRs use Rout instead
ALU_Sel  out  6  ALU operation
read  out  1  memory read; also the MDR input mux select
write  out  1  memory write
incPC  out  1  PC increment
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select-and-encode controls
conIn  out  1  CON flip-flop load
halted  out  1  high in HALT state
mem_err  out  1  sticky; set on handshake timeout
instr_count  out  32  retired-instruction count (see optional feature)

Behaviour:
- State register updates on clk rising edge. clr asynchronously forces state T0, clears the wait counter, mem_err and instr_count.
- All control outputs are a combinational decode of the state and ir. Every output not listed for a state is 0. While clr is high, all outputs are 0.
- Opcode classes:
  - ld 00000, ldi 00001, st 00010
  - ALU reg-reg 00011..01010 (ALU_Sel = {1'b0, opcode})
  - ALU immediate 01011..01101, mapped to the add/and/or ALU codes
  - br 10010, jr 10011, nop 11001, halt 11010
  - any other opcode: executed as nop, with illegal pulsed (internal flag, visible in sim)
- Fetch:
  - T0: PC out, MAR in, incPC.
  - T1: read, MDR in. Stays in T1 until mem_ready.
  - T2: MDR out, IR in. Then go to T3.
- ALU reg-reg:
  - T3: Grb, Rout, Y in.
  - T4: Grc, Rout, ALU_Sel = opcode, Zlow in.
  - T5: Zlow out, Gra, Rin. Then T0.
- ALU immediate: same as reg-reg, except T4 drives C_sign_extended onto the bus instead of Grc/Rout.
- ldi:
  - T3: Grb, BAout, Y in.
  - T4: C out, ADD_SEL, Zlow in.
  - T5: Zlow out, Gra, Rin. Then T0.
- ld:
  - T3 and T4 as for ldi.
  - T5: Zlow out, MAR in.
  - T6: read, MDR in; waits for mem_ready.
  - T7: MDR out, Gra, Rin. Then T0.
- st:
  - T3..T5 as for ld.
  - T6: Gra, Rout, MDR in, with read = 0.
  - T7: write; waits for mem_ready. Then T0.
- br:
  - T3: Gra, Rout, conIn.
  - T4: PC out, Y in.
  - T5: C out, ADD_SEL, Zlow in.
  - T6: if con_ff then Zlow out and PC in, otherwise no strobes. Then T0.
- jr: T3: Gra, Rout, PC in. Then T0.
- nop: T3 goes straight to T0.
- halt: enters HALT. halted = 1 and all strobes are 0 until clr.
- Memory wait:
  - The counter loads 0 on entry to a wait state and increments each cycle mem_ready is low.
  - If the count reaches MEM_TIMEOUT, mem_err is set and the FSM enters HALT.
  - If mem_ready is high in the same cycle the timeout is reached, the transfer completes and no error is raised.
- read/write are held stable for the whole wait. write is never asserted together with read.
- clr asserted mid-instruction aborts it; no further strobes are issued.

Optional Feature:
INSTR_COUNT_EN:
- Defined: instr_count increments by 1 on each transition T2 -> T3, wraps at 2^32, and does not count in HALT.
- Undefined: instr_count is tied to 32'd0 and no counter flops exist.

Test Plan:
- Reset then fetch with mem_ready = 1 and IR = add R1,R2,R3: T0..T5 in 6 cycles; reg_enable[19] high with ALU_Sel = 6'd3 in T4; Rin with Gra in T5; back to T0.
- ld R4,0x10(R0) with mem_ready delayed 3 cycles in T6: read held 4 cycles, then MDR out + Rin in T7; total 11 cycles.
- st with mem_ready delayed 2 cycles: write high 3 cycles; read = 0 throughout T6..T7.
- br with con_ff = 0, then = 1: PC in asserted in T6 only when con_ff = 1.
- mem_ready held low in T1 with MEM_TIMEOUT = 15: after 15 wait cycles mem_err = 1 and halted = 1; clr clears both and restarts at T0.
- halt opcode 11010 after 3 instructions, with INSTR_COUNT_EN defined: halted = 1, all strobes 0, instr_count = 4 and stable.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute controller for the single-bus CPU.
// Define INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
module control_sequencer #(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [5:0] ADD_SEL     = 6'd3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic [31:0] reg_enable,
  output logic [31:0] bus_sel,
  output logic [5:0]  ALU_Sel,
  output logic        read,
  output logic        write,
  output logic        incPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        conIn,
  output logic        halted,
  output logic        mem_err,
  output logic [31:0] instr_count
);
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  localparam int RZ = 19, RPC = 20, RIR = 21, RMDR = 22, RMAR = 23, RY = 24;
  localparam int BZ = 19, BPC = 20, BMDR = 21, BC = 23;
  state_t state;
  logic [7:0] wcnt;
  logic [4:0] op;
  logic [5:0] imm_sel;
  logic is_ld, is_ldi, is_st, is_alu, is_imm, is_br, is_jr, is_nop, is_halt;
  logic mem_op, wb, illegal, wt, tmo;
  logic unused_ir;
  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld     = op == 5'b00000;
  assign is_ldi    = op == 5'b00001;
  assign is_st     = op == 5'b00010;
  assign is_alu    = op >= 5'b00011 && op <= 5'b01010;
  assign is_imm    = op >= 5'b01011 && op <= 5'b01101;
  assign is_br     = op == 5'b10010;
  assign is_jr     = op == 5'b10011;
  assign is_nop    = op == 5'b11001;
  assign is_halt   = op == 5'b11010;
  assign mem_op    = is_ld || is_ldi || is_st;
  assign wb        = is_alu || is_imm || is_ldi;
  assign illegal   = state == T3 && !(mem_op || is_alu || is_imm || is_br || is_jr || is_nop || is_halt);
  assign imm_sel   = op == 5'b01011 ? ADD_SEL : op == 5'b01100 ? 6'd5 : 6'd6;
  // wait states: fetch read, ld operand read, st write
  assign wt        = state == T1 || (state == T6 && is_ld) || (state == T7 && is_st);
  assign tmo       = !mem_ready && wcnt + 8'd1 == TMO;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state   <= T0;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      wcnt <= wt && !mem_ready ? wcnt + 8'd1 : '0;
      if (wt && tmo) mem_err <= 1'b1;
      case (state)
        T0:      state <= T1;
        T1:      state <= mem_ready ? T2 : tmo ? HALT : T1;
        T2:      state <= T3;
        T3:      state <= is_halt ? HALT : (is_jr || is_nop || illegal) ? T0 : T4;
        T4:      state <= T5;
        T5:      state <= (is_ld || is_st || is_br) ? T6 : T0;
        T6:      state <= is_ld ? (mem_ready ? T7 : tmo ? HALT : T6) : is_st ? T7 : T0;
        T7:      state <= !is_st || mem_ready ? T0 : tmo ? HALT : T7;
        default: state <= HALT;
      endcase
    end
  always_comb begin
    reg_enable = '0;
    bus_sel    = '0;
    ALU_Sel    = '0;
    read       = 1'b0;
    write      = 1'b0;
    incPC      = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    conIn      = 1'b0;
    halted     = 1'b0;
    if (!clr)
      case (state)
        T0: begin
          bus_sel[BPC]     = 1'b1;
          reg_enable[RMAR] = 1'b1;
          incPC            = 1'b1;
        end
        T1: begin
          read             = 1'b1;
          reg_enable[RMDR] = 1'b1;
        end
        T2: begin
          bus_sel[BMDR]   = 1'b1;
          reg_enable[RIR] = 1'b1;
        end
        T3: begin
          Gra             = is_br || is_jr;
          Grb             = is_alu || is_imm || mem_op;
          Rout            = is_alu || is_imm || is_br || is_jr;
          BAout           = mem_op;
          reg_enable[RY]  = is_alu || is_imm || mem_op;
          reg_enable[RPC] = is_jr;
          conIn           = is_br;
        end
        T4: begin
          Grc            = is_alu;
          Rout           = is_alu;
          bus_sel[BC]    = is_imm || mem_op;
          bus_sel[BPC]   = is_br;
          reg_enable[RY] = is_br;
          reg_enable[RZ] = is_alu || is_imm || mem_op;
          ALU_Sel        = is_alu ? {1'b0, op} : is_imm ? imm_sel : mem_op ? ADD_SEL : 6'd0;
        end
        T5: begin
          bus_sel[BZ]      = wb || is_ld || is_st;
          Gra              = wb;
          Rin              = wb;
          reg_enable[RMAR] = is_ld || is_st;
          bus_sel[BC]      = is_br;
          reg_enable[RZ]   = is_br;
          ALU_Sel          = is_br ? ADD_SEL : 6'd0;
        end
        T6: begin
          read             = is_ld;
          reg_enable[RMDR] = is_ld || is_st;
          Gra              = is_st;
          Rout             = is_st;
          bus_sel[BZ]      = is_br && con_ff;
          reg_enable[RPC]  = is_br && con_ff;
        end
        T7: begin
          bus_sel[BMDR] = is_ld;
          Gra           = is_ld;
          Rin           = is_ld;
          write         = is_st;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
  end
`ifdef INSTR_COUNT_EN
  always_ff @(posedge clk or posedge clr)
    if (clr) instr_count <= '0;
    else if (state == T2) instr_count <= instr_count + 32'd1;
`else
  assign instr_count = '0;
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer, per-cycle strobe expectations.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic clr, con_ff, mem_ready;
  logic [31:0] ir;
  logic [31:0] reg_enable, bus_sel, instr_count;
  logic [5:0] ALU_Sel;
  logic read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn, halted, mem_err;
  logic [10:0] ctl_o;
  int vectors = 0;
  int errors = 0;

  localparam logic [31:0] R_Z = 32'h0008_0000, R_PC = 32'h0010_0000, R_IR = 32'h0020_0000;
  localparam logic [31:0] R_MDR = 32'h0040_0000, R_MAR = 32'h0080_0000, R_Y = 32'h0100_0000;
  localparam logic [31:0] B_Z = 32'h0008_0000, B_PC = 32'h0010_0000, B_MDR = 32'h0020_0000, B_C = 32'h0080_0000;
  localparam logic [10:0] C_RD = 11'h400, C_WR = 11'h200, C_INC = 11'h100, C_GRA = 11'h080, C_GRB = 11'h040;
  localparam logic [10:0] C_GRC = 11'h020, C_RIN = 11'h010, C_ROUT = 11'h008, C_BA = 11'h004, C_CON = 11'h002, C_HLT = 11'h001;
`ifdef INSTR_COUNT_EN
  localparam logic [31:0] EXP_CNT = 32'd4;
`else
  localparam logic [31:0] EXP_CNT = 32'd0;
`endif

  typedef struct {
    logic [31:0] re;
    logic [31:0] bs;
    logic [5:0]  alu;
    logic [10:0] ctl;
    logic        rdy;
  } ent_t;
  ent_t q[$];

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .reg_enable(reg_enable), .bus_sel(bus_sel), .ALU_Sel(ALU_Sel), .read(read), .write(write),
    .incPC(incPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .conIn(conIn), .halted(halted), .mem_err(mem_err), .instr_count(instr_count)
  );

  assign ctl_o = {read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn, halted};
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [4:0] o, input logic [3:0] ra, rb, rc, input logic [14:0] c);
    return {o, ra, rb, rc, c};
  endfunction

  task automatic push(input logic [31:0] re, bs, input logic [5:0] alu, input logic [10:0] ctl, input logic rdy);
    q.push_back('{re, bs, alu, ctl, rdy});
  endtask

  task automatic push_fetch(input int d);
    push(R_MAR, B_PC, 6'd0, C_INC, 1'b0);
    for (int i = 0; i < d; i++) push(R_MDR, '0, 6'd0, C_RD, 1'b0);
    push(R_MDR, '0, 6'd0, C_RD, 1'b1);
    push(R_IR, B_MDR, 6'd0, '0, 1'b0);
  endtask

  task automatic push_addr();
    push(R_Y, '0, 6'd0, C_GRB | C_BA, 1'b0);
    push(R_Z, B_C, 6'd3, '0, 1'b0);
  endtask

  task automatic drain(input string nm);
    ent_t e;
    int n;
    n = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.rdy;
      @(negedge clk);
      vectors++;
      if ({reg_enable, bus_sel, ALU_Sel, ctl_o} !== {e.re, e.bs, e.alu, e.ctl}) begin
        errors++;
        $display("FAIL %s cyc %0d: got re=%h bs=%h alu=%0d ctl=%b, want re=%h bs=%h alu=%0d ctl=%b",
                 nm, n, reg_enable, bus_sel, ALU_Sel, ctl_o, e.re, e.bs, e.alu, e.ctl);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({reg_enable, bus_sel, ALU_Sel, ctl_o, mem_err, instr_count} !== '0) begin
      errors++;
      $display("FAIL reset: got re=%h bs=%h alu=%0d ctl=%b err=%b cnt=%0d, want all 0",
               reg_enable, bus_sel, ALU_Sel, ctl_o, mem_err, instr_count);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_alu();
    logic [4:0] ops[5] = '{5'b00011, 5'b00100, 5'b01011, 5'b01100, 5'b01101};
    logic [5:0] sel[5] = '{6'd3, 6'd4, 6'd3, 6'd5, 6'd6};
    for (int i = 0; i < 5; i++) begin
      ir = enc(ops[i], 4'd1, 4'd2, 4'd3, 15'd0);
      push_fetch(0);
      push(R_Y, '0, 6'd0, C_GRB | C_ROUT, 1'b0);
      if (i < 2) push(R_Z, '0, sel[i], C_GRC | C_ROUT, 1'b0);
      else push(R_Z, B_C, sel[i], '0, 1'b0);
      push('0, B_Z, 6'd0, C_GRA | C_RIN, 1'b0);
      drain($sformatf("alu_op%b", ops[i]));
    end
  endtask

  task automatic test_load();
    ir = enc(5'b00001, 4'd5, 4'd0, 4'd0, 15'd7);
    push_fetch(0);
    push_addr();
    push('0, B_Z, 6'd0, C_GRA | C_RIN, 1'b0);
    drain("ldi");
    ir = enc(5'b00000, 4'd4, 4'd0, 4'd0, 15'h10);
    push_fetch(0);
    push_addr();
    push(R_MAR, B_Z, 6'd0, '0, 1'b0);
    repeat (3) push(R_MDR, '0, 6'd0, C_RD, 1'b0);
    push(R_MDR, '0, 6'd0, C_RD, 1'b1);
    push('0, B_MDR, 6'd0, C_GRA | C_RIN, 1'b0);
    drain("ld");
  endtask

  task automatic test_store();
    ir = enc(5'b00010, 4'd6, 4'd1, 4'd0, 15'h20);
    push_fetch(0);
    push_addr();
    push(R_MAR, B_Z, 6'd0, '0, 1'b0);
    push(R_MDR, '0, 6'd0, C_GRA | C_ROUT, 1'b0);
    repeat (2) push('0, '0, 6'd0, C_WR, 1'b0);
    push('0, '0, 6'd0, C_WR, 1'b1);
    drain("st");
  endtask

  task automatic test_branch();
    for (int c = 0; c < 2; c++) begin
      con_ff = c[0];
      ir = enc(5'b10010, 4'd2, 4'd0, 4'd0, 15'd8);
      push_fetch(0);
      push('0, '0, 6'd0, C_GRA | C_ROUT | C_CON, 1'b0);
      push(R_Y, B_PC, 6'd0, '0, 1'b0);
      push(R_Z, B_C, 6'd3, '0, 1'b0);
      if (c == 1) push(R_PC, B_Z, 6'd0, '0, 1'b0);
      else push('0, '0, 6'd0, '0, 1'b0);
      drain($sformatf("br_con%0d", c));
    end
    con_ff = 1'b0;
  endtask

  task automatic test_back_to_back();
    ir = enc(5'b10011, 4'd3, 4'd0, 4'd0, 15'd0);
    push_fetch(0);
    push(R_PC, '0, 6'd0, C_GRA | C_ROUT, 1'b0);
    drain("jr");
    ir = enc(5'b11001, 4'd0, 4'd0, 4'd0, 15'd0);
    push_fetch(0);
    push('0, '0, 6'd0, '0, 1'b0);
    drain("nop");
    ir = enc(5'b11111, 4'd1, 4'd1, 4'd1, 15'd0);
    push_fetch(1);
    push('0, '0, 6'd0, '0, 1'b0);
    drain("illegal");
    ir = enc(5'b00011, 4'd7, 4'd8, 4'd9, 15'd0);
    push_fetch(0);
    push(R_Y, '0, 6'd0, C_GRB | C_ROUT, 1'b0);
    push(R_Z, '0, 6'd3, C_GRC | C_ROUT, 1'b0);
    push('0, B_Z, 6'd0, C_GRA | C_RIN, 1'b0);
    drain("add_after_illegal");
  endtask

  task automatic test_mem_boundary();
    ir = enc(5'b11001, 4'd0, 4'd0, 4'd0, 15'd0);
    push_fetch(14);
    push('0, '0, 6'd0, '0, 1'b0);
    drain("ready_at_limit");
    vectors++;
    if (mem_err !== 1'b0) begin
      errors++;
      $display("FAIL ready_at_limit mem_err: got %b want 0", mem_err);
    end
  endtask

  task automatic test_timeout();
    ir = enc(5'b11001, 4'd0, 4'd0, 4'd0, 15'd0);
    push(R_MAR, B_PC, 6'd0, C_INC, 1'b0);
    repeat (15) push(R_MDR, '0, 6'd0, C_RD, 1'b0);
    repeat (3) push('0, '0, 6'd0, C_HLT, 1'b0);
    drain("timeout");
    vectors++;
    if (mem_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout mem_err: got %b want 1", mem_err);
    end
    clr = 1'b1;
    #1;
    vectors++;
    if ({mem_err, halted} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_clr: got err=%b halted=%b want 0 0", mem_err, halted);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    push_fetch(0);
    push('0, '0, 6'd0, '0, 1'b0);
    drain("restart");
  endtask

  task automatic test_abort();
    ir = enc(5'b00011, 4'd1, 4'd2, 4'd3, 15'd0);
    push_fetch(0);
    push(R_Y, '0, 6'd0, C_GRB | C_ROUT, 1'b0);
    drain("abort_pre");
    #1;
    clr = 1'b1;
    #1;
    vectors++;
    if ({reg_enable, bus_sel, ALU_Sel, ctl_o} !== '0) begin
      errors++;
      $display("FAIL abort_clr: got re=%h bs=%h alu=%0d ctl=%b want all 0", reg_enable, bus_sel, ALU_Sel, ctl_o);
    end
    #1;
    clr = 1'b0;
    ir = enc(5'b11001, 4'd0, 4'd0, 4'd0, 15'd0);
    push_fetch(0);
    push('0, '0, 6'd0, '0, 1'b0);
    drain("abort_restart");
  endtask

  task automatic test_halt();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    ir = enc(5'b11001, 4'd0, 4'd0, 4'd0, 15'd0);
    push_fetch(0);
    push('0, '0, 6'd0, '0, 1'b0);
    drain("halt_nop");
    ir = enc(5'b10011, 4'd3, 4'd0, 4'd0, 15'd0);
    push_fetch(0);
    push(R_PC, '0, 6'd0, C_GRA | C_ROUT, 1'b0);
    drain("halt_jr");
    ir = enc(5'b00011, 4'd1, 4'd2, 4'd3, 15'd0);
    push_fetch(0);
    push(R_Y, '0, 6'd0, C_GRB | C_ROUT, 1'b0);
    push(R_Z, '0, 6'd3, C_GRC | C_ROUT, 1'b0);
    push('0, B_Z, 6'd0, C_GRA | C_RIN, 1'b0);
    drain("halt_add");
    ir = enc(5'b11010, 4'd0, 4'd0, 4'd0, 15'd0);
    push_fetch(0);
    push('0, '0, 6'd0, '0, 1'b0);
    repeat (4) push('0, '0, 6'd0, C_HLT, 1'b1);
    drain("halt");
    vectors++;
    if (instr_count !== EXP_CNT) begin
      errors++;
      $display("FAIL halt_count: got %0d want %0d", instr_count, EXP_CNT);
    end
    con_ff = 1'b1;
    repeat (5) push('0, '0, 6'd0, C_HLT, 1'b0);
    drain("halt_stay");
    vectors++;
    if (instr_count !== EXP_CNT) begin
      errors++;
      $display("FAIL halt_count_stable: got %0d want %0d", instr_count, EXP_CNT);
    end
  endtask

  initial begin
    clr = 1'b1;
    ir = '0;
    con_ff = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_mem_boundary();
    test_timeout();
    test_abort();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
